time_display: RTL



---
 rtl/time_display.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/time_display.sv
// time_display: converts a 15-bit binary count to 5 BCD digits with a sequential
// shift-add-3 engine and drives five active-low 7-segment displays with
// leading-zero blanking. Outputs update only when a conversion completes.
// Optional feature macro: BLINK_ZERO_EN (blinks all displays while bcd is zero).
module time_display #(
   parameter int unsigned BLINK_DIV = 25000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [14:0] value,
   output logic [19:0] bcd,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic        busy
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StShift = 2'd1,
      StLoad  = 2'd2
   } state_e;

   localparam logic [6:0] SegBlank = 7'h7F;
   localparam logic [6:0] SegZero  = 7'h40;

   // Active-low segment pattern for one digit; anything outside 0..9 is blank.
   function automatic logic [6:0] seg_of(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SegBlank;
      endcase
      return s;
   endfunction

   state_e      r_state, w_state_nxt;
   logic [14:0] r_last_value, w_last_value_nxt;
   logic [14:0] r_shreg, w_shreg_nxt;
   logic [19:0] r_acc, w_acc_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic [19:0] r_bcd, w_bcd_nxt;
   logic [6:0]  r_hex0, r_hex1, r_hex2, r_hex3, r_hex4;
   logic [6:0]  w_hex0_nxt, w_hex1_nxt, w_hex2_nxt, w_hex3_nxt, w_hex4_nxt;
   logic        r_busy;

   logic [19:0] w_adj;
   logic [4:0]  w_nz;

   // Add-3 correction on every accumulator nibble that is 5 or more.
   always_comb begin
      w_adj = r_acc;
      for (int i = 0; i < 5; i++) begin
         if (r_acc[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
         end
      end
   end

   // Per-digit nonzero flags of the finished accumulator, used for blanking.
   always_comb begin
      for (int i = 0; i < 5; i++) begin
         w_nz[i] = (r_acc[4*i +: 4] != 4'd0);
      end
   end

   // Next-state and datapath updates for the IDLE/SHIFT/LOAD conversion FSM.
   always_comb begin
      w_state_nxt      = r_state;
      w_last_value_nxt = r_last_value;
      w_shreg_nxt      = r_shreg;
      w_acc_nxt        = r_acc;
      w_cnt_nxt        = r_cnt;
      w_bcd_nxt        = r_bcd;
      w_hex0_nxt       = r_hex0;
      w_hex1_nxt       = r_hex1;
      w_hex2_nxt       = r_hex2;
      w_hex3_nxt       = r_hex3;
      w_hex4_nxt       = r_hex4;
      case (r_state)
         StIdle: begin
            if (value != r_last_value) begin
               w_last_value_nxt = value;
               w_shreg_nxt      = value;
               w_acc_nxt        = 20'd0;
               w_cnt_nxt        = 4'd0;
               w_state_nxt      = StShift;
            end
         end
         StShift: begin
            w_acc_nxt   = {w_adj[18:0], r_shreg[14]};
            w_shreg_nxt = {r_shreg[13:0], 1'b0};
            w_cnt_nxt   = r_cnt + 4'd1;
            // Counter holds the number of shifts already done; this edge is the 15th.
            if (r_cnt == 4'd14) begin
               w_state_nxt = StLoad;
            end
         end
         StLoad: begin
            w_bcd_nxt   = r_acc;
            w_hex0_nxt  = seg_of(r_acc[3:0]);
            w_hex1_nxt  = (w_nz[4:1] != 4'd0) ? seg_of(r_acc[7:4])   : SegBlank;
            w_hex2_nxt  = (w_nz[4:2] != 3'd0) ? seg_of(r_acc[11:8])  : SegBlank;
            w_hex3_nxt  = (w_nz[4:3] != 2'd0) ? seg_of(r_acc[15:12]) : SegBlank;
            w_hex4_nxt  = w_nz[4]             ? seg_of(r_acc[19:16]) : SegBlank;
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // State and datapath registers; busy is registered from the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= StIdle;
         r_last_value <= 15'd0;
         r_shreg      <= 15'd0;
         r_acc        <= 20'd0;
         r_cnt        <= 4'd0;
         r_bcd        <= 20'd0;
         r_hex0       <= SegZero;
         r_hex1       <= SegBlank;
         r_hex2       <= SegBlank;
         r_hex3       <= SegBlank;
         r_hex4       <= SegBlank;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_last_value <= w_last_value_nxt;
         r_shreg      <= w_shreg_nxt;
         r_acc        <= w_acc_nxt;
         r_cnt        <= w_cnt_nxt;
         r_bcd        <= w_bcd_nxt;
         r_hex0       <= w_hex0_nxt;
         r_hex1       <= w_hex1_nxt;
         r_hex2       <= w_hex2_nxt;
         r_hex3       <= w_hex3_nxt;
         r_hex4       <= w_hex4_nxt;
         r_busy       <= (w_state_nxt != StIdle);
      end
   end

   assign bcd  = r_bcd;
   assign busy = r_busy;

`ifdef BLINK_ZERO_EN
   logic [24:0] r_blink_cnt;
   logic        r_phase;
   logic        w_blank_all;

   // Blink half-period counter; phase toggles each time the counter wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_blink_cnt <= 25'd0;
         r_phase     <= 1'b1;
      end else if (r_blink_cnt == 25'(BLINK_DIV - 1)) begin
         r_blink_cnt <= 25'd0;
         r_phase     <= ~r_phase;
      end else begin
         r_blink_cnt <= r_blink_cnt + 25'd1;
      end
   end

   // A zero result is the expired-timer indication: flash the whole display.
   assign w_blank_all = (r_bcd == 20'd0) && !r_phase;
   assign hex0 = w_blank_all ? SegBlank : r_hex0;
   assign hex1 = w_blank_all ? SegBlank : r_hex1;
   assign hex2 = w_blank_all ? SegBlank : r_hex2;
   assign hex3 = w_blank_all ? SegBlank : r_hex3;
   assign hex4 = w_blank_all ? SegBlank : r_hex4;
`else
   logic w_unused_blink_div;
   assign w_unused_blink_div = ^BLINK_DIV;

   assign hex0 = r_hex0;
   assign hex1 = r_hex1;
   assign hex2 = r_hex2;
   assign hex3 = r_hex3;
   assign hex4 = r_hex4;
`endif

endmodule
